serial_parallel_align: RTL and testbench

Parametrised serial-to-parallel receiver for the PHY RX path, clocked by the bit clock `clk_32f`. It shifts in one serial bit per cycle and searches for a comma word at any bit offset. After a run of `LOCK_COUNT` consecutive aligned commas it locks word alignment. In lock it deserialises each `WIDTH`-bit word and distributes it round-robin across `LANES` parallel outputs with per-lane valid strobes, replacing the fixed 8-bit/4-lane demux chain.

---
 rtl/serial_parallel_align.sv | 151 +++++++++++++++
 tb/tb_serial_parallel_align.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parallel_align.sv
// serial_parallel_align -- serial-to-parallel receiver with comma alignment.
//
// Shifts in one bit per clk_32f edge, hunts for COMMA at any bit offset, and
// once LOCK_COUNT back-to-back aligned commas have been seen it locks the word
// boundary. Locked words are distributed round-robin over LANES outputs.
//
// Ports:
//   clk_32f    in   bit clock, all logic on rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   serial bit, MSB of each word first
//   data_out   out  LANES*WIDTH, lane i at [i*WIDTH +: WIDTH], holds last value
//   valid_out  out  LANES, one-cycle pulse when a lane receives a data word
//   active     out  high while word alignment is locked

// One output lane: captures the word on wr, pulses valid only for data words.
module spa_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             wr,
    input  logic             mark,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] lane_data,
    output logic             lane_vld
);
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            lane_data <= '0;
            lane_vld  <= 1'b0;
        end else begin
            // valid is recomputed every edge, so it can never outlive one cycle
            lane_vld <= wr & mark;
            if (wr) lane_data <= wr_data;
        end
    end
endmodule

module serial_parallel_align #(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 4,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
    parameter int               LOCK_COUNT = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   data_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   active
);
    localparam int BC_W = $clog2(WIDTH);
    localparam int LP_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WIDTH - 1);
    localparam logic [LP_W-1:0] LAST_LANE = LP_W'(LANES - 1);
    localparam logic [3:0]      LOCK_N    = 4'(LOCK_COUNT);

    logic [1:0]       state;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] cand;
    logic [BC_W-1:0]  bit_cnt;
    logic [3:0]       comma_cnt;
    logic [LP_W-1:0]  lane_ptr;
    logic             boundary;
    logic             is_comma;
    logic             is_idle;
    logic             lane_step;

    // cand is the word completed by the bit arriving this cycle
    assign cand      = {sr, data_in};
    assign is_comma  = (cand == COMMA);
    assign is_idle   = (cand == IDLE);
    assign boundary  = (state != ST_SEARCH) && (bit_cnt == LAST_BIT);
    // a locked non-comma word consumes the slot at lane_ptr (IDLE included)
    assign lane_step = (state == ST_LOCKED) && boundary && !is_comma;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= ST_SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            lane_ptr  <= '0;
            active    <= 1'b0;
        end else begin
            sr <= cand[WIDTH-2:0];

            // bit_cnt only means something once a comma has fixed the phase
            if (state == ST_SEARCH || boundary) bit_cnt <= '0;
            else                                bit_cnt <= bit_cnt + BC_W'(1);

            case (state)
                ST_SEARCH: begin
                    if (is_comma) begin
                        comma_cnt <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state    <= ST_LOCKED;
                            active   <= 1'b1;
                            lane_ptr <= '0;
                        end else begin
                            state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if (comma_cnt + 4'd1 == LOCK_N) begin
                                state    <= ST_LOCKED;
                                active   <= 1'b1;
                                lane_ptr <= '0;
                            end
                        end else begin
                            // the failing word is not re-tested; search resumes next edge
                            state     <= ST_SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // only reset leaves lock
                    if (boundary) begin
                        if (is_comma)                   lane_ptr <= '0;
                        else if (lane_ptr == LAST_LANE) lane_ptr <= '0;
                        else                            lane_ptr <= lane_ptr + LP_W'(1);
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        spa_lane #(.WIDTH(WIDTH)) u_lane (
            .clk_32f   (clk_32f),
            .reset     (reset),
            .wr        (lane_step && (lane_ptr == LP_W'(i))),
            .mark      (!is_idle),
            .wr_data   (cand),
            .lane_data (data_out[i*WIDTH +: WIDTH]),
            .lane_vld  (valid_out[i])
        );
    end
endmodule

// File: tb/tb_serial_parallel_align.sv
module tb_serial_parallel_align;
    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic        reset = 1'b1;
    logic        din_a = 1'b0;
    logic        din_b = 1'b0;
    logic [31:0] dout_a;
    logic [3:0]  vld_a;
    logic        act_a;
    logic [29:0] dout_b;
    logic [2:0]  vld_b;
    logic        act_b;

    serial_parallel_align dut_a (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (din_a),
        .data_out  (dout_a),
        .valid_out (vld_a),
        .active    (act_a)
    );

    serial_parallel_align #(
        .WIDTH(10), .LANES(3), .COMMA(10'h17C), .IDLE(10'h283), .LOCK_COUNT(2)
    ) dut_b (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (din_b),
        .data_out  (dout_b),
        .valid_out (vld_b),
        .active    (act_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // active configuration
    int          W, L, LC;
    logic [15:0] CM, ID;

    task automatic set_cfg(input int c);
        if (c == 0) begin W = 8;  L = 4; LC = 4; CM = 16'h0BC; ID = 16'h07C; end
        else        begin W = 10; L = 3; LC = 2; CM = 16'h17C; ID = 16'h283; end
    endtask

    // stream after reset, and expected outputs after each edge
    bit          bits[$];
    bit          e_act[$];
    logic [63:0] e_dat[$];
    logic [63:0] e_vld[$];

    task automatic push_word(input logic [15:0] w);
        for (int k = W - 1; k >= 0; k--) bits.push_back(w[k]);
    endtask

    task automatic push_rand(input int n);
        for (int k = 0; k < n; k++) bits.push_back(bit'($urandom_range(0, 1)));
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] v;
        v = 16'($urandom) & ((16'd1 << W) - 16'd1);
        if (v == CM || v == ID) v = v ^ 16'd1;
        return v;
    endfunction

    // word whose last bit is stream bit t; bits before the stream are zero
    function automatic logic [15:0] word_at(input int t);
        logic [15:0] v = '0;
        for (int k = 0; k < W; k++) begin
            int idx = t - W + 1 + k;
            v = {v[14:0], (idx >= 0) ? bits[idx] : 1'b0};
        end
        return v;
    endfunction

    // Reference: find the lock point by scanning for comma runs, then walk
    // word boundaries after it and distribute words round-robin.
    task automatic build_model();
        int n = bits.size();
        int lock_t = -1;
        int t = 0;
        int ptr = 0;
        bit act = 0;
        logic [63:0] dat = '0;
        logic [63:0] vld;
        while (t < n && lock_t < 0) begin
            if (word_at(t) == CM) begin
                int k = 1;
                int u = t;
                while (k < LC && u + W < n && word_at(u + W) == CM) begin
                    u += W;
                    k++;
                end
                if (k == LC)        lock_t = u;
                else if (u + W < n) t = u + W + 1;
                else                t = n;
            end else begin
                t++;
            end
        end
        e_act.delete(); e_dat.delete(); e_vld.delete();
        for (int e = 0; e < n; e++) begin
            vld = '0;
            if (lock_t >= 0 && e == lock_t) begin
                act = 1;
                ptr = 0;
            end else if (lock_t >= 0 && e > lock_t && (e - lock_t) % W == 0) begin
                logic [15:0] w = word_at(e);
                if (w == CM) ptr = 0;
                else begin
                    for (int k = 0; k < W; k++) dat[ptr*W + k] = w[k];
                    if (w != ID) vld[ptr] = 1'b1;
                    ptr = (ptr + 1) % L;
                end
            end
            e_act.push_back(act);
            e_dat.push_back(dat);
            e_vld.push_back(vld);
        end
    endtask

    function automatic logic [63:0] get_act(input int c);
        return (c == 0) ? 64'(act_a) : 64'(act_b);
    endfunction
    function automatic logic [63:0] get_dat(input int c);
        return (c == 0) ? 64'(dout_a) : 64'(dout_b);
    endfunction
    function automatic logic [63:0] get_vld(input int c);
        return (c == 0) ? 64'(vld_a) : 64'(vld_b);
    endfunction

    task automatic drive(input int c, input bit b);
        if (c == 0) din_a = b;
        else        din_b = b;
    endtask

    // reset 3 cycles (random data), then play bits and compare every cycle
    task automatic run_scenario(input int c, output int rise, output int npulse);
        build_model();
        reset = 1'b1;
        repeat (3) begin
            drive(c, bit'($urandom_range(0, 1)));
            @(posedge clk_32f); #1;
            chk("rst_active", get_act(c), 64'd0);
            chk("rst_data", get_dat(c), 64'd0);
            chk("rst_valid", get_vld(c), 64'd0);
        end
        reset  = 1'b0;
        rise   = -1;
        npulse = 0;
        for (int e = 0; e < bits.size(); e++) begin
            drive(c, bits[e]);
            @(posedge clk_32f); #1;
            chk("active", get_act(c), 64'(e_act[e]));
            chk("data_out", get_dat(c), e_dat[e]);
            chk("valid_out", get_vld(c), e_vld[e]);
            if (rise < 0 && get_act(c) == 64'd1) rise = e;
            npulse += $countones(get_vld(c));
        end
    endtask

    initial begin
        int rise, np;

        // basic aligned lock
        set_cfg(0); bits.delete();
        repeat (4) push_word(CM);
        push_word(16'hAA); push_word(16'h55); push_word(16'h12); push_word(16'h34);
        run_scenario(0, rise, np);
        chk("basic_rise", 64'(rise), 64'd31);
        chk("basic_pulses", 64'(np), 64'd4);
        chk("basic_lanes", get_dat(0), 64'h341255AA);

        // misaligned start (also reset while locked)
        bits.delete();
        push_rand(3);
        repeat (4) push_word(CM);
        push_word(16'hAA); push_word(16'h55); push_word(16'h12); push_word(16'h34);
        run_scenario(0, rise, np);
        chk("misalign_rise", 64'(rise), 64'd34);
        chk("misalign_lanes", get_dat(0), 64'h341255AA);

        // broken comma run
        bits.delete();
        push_word(CM); push_word(CM); push_word(16'h00);
        repeat (4) push_word(CM);
        push_word(16'hAA);
        run_scenario(0, rise, np);
        chk("broken_rise", 64'(rise), 64'd55);

        // IDLE and comma while locked
        bits.delete();
        repeat (4) push_word(CM);
        push_word(16'hAA); push_word(ID); push_word(CM); push_word(16'h55);
        run_scenario(0, rise, np);
        chk("idle_pulses", 64'(np), 64'd2);
        chk("idle_lanes", get_dat(0), 64'h00007C55);

        // 10-bit / 3-lane / lock-after-2 configuration
        set_cfg(1); bits.delete();
        repeat (2) push_word(CM);
        repeat (4) push_word(rand_data());
        run_scenario(1, rise, np);
        chk("sweep_rise", 64'(rise), 64'd19);
        chk("sweep_pulses", 64'(np), 64'd4);

        // randomized streams on both configurations
        for (int r = 0; r < 8; r++) begin
            int c = r % 2;
            set_cfg(c); bits.delete();
            push_rand(int'($urandom_range(0, W - 1)));
            if (r >= 2) begin push_word(CM); push_word(rand_data()); end
            repeat (LC) push_word(CM);
            repeat (24) begin
                int p = int'($urandom_range(0, 9));
                if (p == 0)     push_word(CM);
                else if (p < 3) push_word(ID);
                else            push_word(rand_data());
            end
            push_rand(int'($urandom_range(0, W - 1)));
            run_scenario(c, rise, np);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
